// File: rtl/cache_refill_ctrl_pkg.sv
// rtl/cache_refill_ctrl_pkg.sv - shared geometry, state encoding and PLRU helpers for the refill controller
package cache_refill_ctrl_pkg;

  localparam int LINE_BYTES = 64;
  localparam int BEATS      = 8;
  localparam int INDEX_W    = 8;
  localparam int OFFSET_W   = 6;
  localparam int WAYS       = 4;
  localparam int WAY_W      = 2;
  localparam int BEAT_W     = 3;
  localparam int SETS       = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } refill_state_e;

  function automatic logic [WAY_W-1:0] plru_victim(input logic [2:0] bits);
    if (bits[0]) return bits[2] ? 2'd3 : 2'd2;
    return bits[1] ? 2'd1 : 2'd0;
  endfunction

  // Touching a way steers the root and its own leaf away from it; the other leaf is kept.
  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [WAY_W-1:0] way);
    logic [2:0] nb;
    nb    = bits;
    nb[0] = ~way[1];
    if (!way[1]) nb[1] = (way == 2'd0);
    else         nb[2] = (way == 2'd2);
    return nb;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - miss, hit, backing-RAM and fill signals of the refill controller
interface cache_refill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  import cache_refill_ctrl_pkg::*;

  logic                          miss_valid_i;
  logic [ADDR_W-1:0]             miss_addr_i;
  logic                          miss_ready_o;
  logic                          hit_valid_i;
  logic [INDEX_W-1:0]            hit_index_i;
  logic [WAY_W-1:0]              hit_way_i;
  logic                          ram_req_o;
  logic [ADDR_W-1:0]             ram_addr_o;
  logic                          ram_gnt_i;
  logic                          ram_rvalid_i;
  logic [DATA_W-1:0]             ram_rdata_i;
  logic                          fill_we_o;
  logic [INDEX_W-1:0]            fill_index_o;
  logic [WAY_W-1:0]              fill_way_o;
  logic [BEAT_W-1:0]             fill_beat_o;
  logic [DATA_W-1:0]             fill_data_o;
  logic [ADDR_W-OFFSET_W-INDEX_W-1:0] fill_tag_o;
  logic                          fill_done_o;

  modport slave (
    input  miss_valid_i, miss_addr_i, hit_valid_i, hit_index_i, hit_way_i,
           ram_gnt_i, ram_rvalid_i, ram_rdata_i,
    output miss_ready_o, ram_req_o, ram_addr_o, fill_we_o, fill_index_o, fill_way_o,
           fill_beat_o, fill_data_o, fill_tag_o, fill_done_o
  );

  modport master (
    output miss_valid_i, miss_addr_i, hit_valid_i, hit_index_i, hit_way_i,
           ram_gnt_i, ram_rvalid_i, ram_rdata_i,
    input  miss_ready_o, ram_req_o, ram_addr_o, fill_we_o, fill_index_o, fill_way_o,
           fill_beat_o, fill_data_o, fill_tag_o, fill_done_o
  );

endinterface

// File: rtl/plru_4way_tree.sv
// rtl/plru_4way_tree.sv - 256-set tree-PLRU state with one victim lookup and two prioritised update ports
module plru_4way_tree
  import cache_refill_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [INDEX_W-1:0] lookup_index_i,
  output logic [WAY_W-1:0]   lookup_victim_o,
  input  logic               fill_upd_i,
  input  logic [INDEX_W-1:0] fill_upd_index_i,
  input  logic [WAY_W-1:0]   fill_upd_way_i,
  input  logic               hit_upd_i,
  input  logic [INDEX_W-1:0] hit_upd_index_i,
  input  logic [WAY_W-1:0]   hit_upd_way_i
);

  logic [2:0] tree_q [SETS];
  logic       hit_apply;

  assign lookup_victim_o = plru_victim(tree_q[lookup_index_i]);

  // A hit to the set being installed is dropped so the fill's access is what sticks.
  assign hit_apply = hit_upd_i && !(fill_upd_i && (fill_upd_index_i == hit_upd_index_i));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SETS; i++) tree_q[i] <= 3'b000;
    end else begin
      if (hit_apply)
        tree_q[hit_upd_index_i] <= plru_touch(tree_q[hit_upd_index_i], hit_upd_way_i);
      if (fill_upd_i)
        tree_q[fill_upd_index_i] <= plru_touch(tree_q[fill_upd_index_i], fill_upd_way_i);
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - line refill FSM: accept miss, burst-read 8 beats, write them and install the tag
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic clk_sys_i,
  input  logic rst_sys_n_i,
  cache_refill_ctrl_if.slave bus
);

  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

  refill_state_e      state_q, state_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [WAY_W-1:0]   victim;

  plru_4way_tree u_plru (
    .clk_i            (clk_sys_i),
    .rst_n_i          (rst_sys_n_i),
    .lookup_index_i   (bus.miss_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W]),
    .lookup_victim_o  (victim),
    .fill_upd_i       (state_q == DONE),
    .fill_upd_index_i (index_q),
    .fill_upd_way_i   (way_q),
    .hit_upd_i        (bus.hit_valid_i),
    .hit_upd_index_i  (bus.hit_index_i),
    .hit_upd_way_i    (bus.hit_way_i)
  );

  always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) begin
      state_q <= IDLE;
      index_q <= '0;
      tag_q   <= '0;
      base_q  <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      tag_q   <= tag_d;
      base_q  <= base_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    tag_d   = tag_q;
    base_d  = base_q;
    way_d   = way_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    beat_d  = beat_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.miss_valid_i) begin
          index_d = bus.miss_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
          tag_d   = bus.miss_addr_i[ADDR_W-1:OFFSET_W+INDEX_W];
          base_d  = bus.miss_addr_i & ~OFF_MASK;
          way_d   = victim;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.ram_gnt_i) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        // cnt_q[3] marks all eight beats received; stray beats after that are dropped.
        if (bus.ram_rvalid_i && !cnt_q[3]) begin
          we_d   = 1'b1;
          beat_d = cnt_q[BEAT_W-1:0];
          data_d = bus.ram_rdata_i;
          cnt_d  = cnt_q + 4'd1;
        end
        if (we_q && (&beat_q)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.miss_ready_o = (state_q == IDLE);
  assign bus.ram_req_o    = (state_q == REQ);
  assign bus.ram_addr_o   = (state_q == REQ) ? base_q : '0;
  assign bus.fill_we_o    = we_q;
  assign bus.fill_index_o = index_q;
  assign bus.fill_way_o   = way_q;
  assign bus.fill_beat_o  = beat_q;
  assign bus.fill_data_o  = data_q;
  assign bus.fill_tag_o   = tag_q;
  assign bus.fill_done_o  = (state_q == DONE);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - directed table, hand sequences and random misses against a recency model
module tb_cache_refill_ctrl;
  import cache_refill_ctrl_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_refill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_refill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_sys_i   (clk),
    .rst_sys_n_i (rst_n),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [7:0]  idx;
    logic [1:0]  way;
    logic [2:0]  beat;
    logic [63:0] data;
  } wr_t;

  wr_t         wr_q[$];
  int          done_cnt;
  int          done_cyc;
  logic [17:0] done_tag;
  logic [7:0]  done_idx;
  logic [1:0]  done_way;

  // Model: each set remembers which half and, per half, which way is least recently used.
  int m_half [256];
  int m_pick [256][2];

  function automatic void m_reset();
    for (int i = 0; i < 256; i++) begin
      m_half[i] = 0; m_pick[i][0] = 0; m_pick[i][1] = 0;
    end
  endfunction

  function automatic int m_victim(input int idx);
    return m_half[idx] * 2 + m_pick[idx][m_half[idx]];
  endfunction

  function automatic void m_touch(input int idx, input int w);
    m_half[idx] = (w < 2) ? 1 : 0;
    m_pick[idx][w / 2] = 1 - (w % 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fill_we_o)
        wr_q.push_back('{bus.fill_index_o, bus.fill_way_o, bus.fill_beat_o, bus.fill_data_o});
      if (bus.fill_done_o) begin
        done_cnt++;
        done_cyc = cyc;
        done_tag = bus.fill_tag_o;
        done_idx = bus.fill_index_o;
        done_way = bus.fill_way_o;
      end
      if (bus.fill_we_o || bus.fill_done_o)
        check("we_done_exclusive", {63'd0, bus.fill_we_o & bus.fill_done_o}, 64'd0);
    end
  end

  task automatic do_hit(input logic [7:0] idx, input logic [1:0] way);
    bus.hit_valid_i = 1'b1; bus.hit_index_i = idx; bus.hit_way_i = way;
    step();
    bus.hit_valid_i = 1'b0;
    m_touch(int'(idx), int'(way));
  endtask

  task automatic run_miss(input string name, input logic [31:0] addr, input int gd, input int gap,
                          input bit hen, input logic [7:0] hidx, input logic [1:0] hway);
    logic [7:0]  idx;
    logic [1:0]  ew;
    logic [63:0] d;
    logic [31:0] base;
    int          acc, t;
    wr_t         exp_q[$];
    idx  = addr[13:6];
    ew   = 2'(m_victim(int'(idx)));
    base = addr & 32'hFFFF_FFC0;
    wr_q.delete();
    done_cnt = 0;
    check({name, "_ready"}, {63'd0, bus.miss_ready_o}, 64'd1);
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = addr;
    step();
    bus.miss_valid_i = 1'b0; bus.miss_addr_i = $urandom;
    acc = cyc;
    for (int i = 0; i <= gd; i++) begin
      bus.ram_gnt_i = (i == gd);
      bus.ram_rvalid_i = 1'b1; bus.ram_rdata_i = {$urandom, $urandom};
      check($sformatf("%s_req%0d", name, i), {63'd0, bus.ram_req_o}, 64'd1);
      check($sformatf("%s_addr%0d", name, i), {32'd0, bus.ram_addr_o}, {32'd0, base});
      step();
    end
    bus.ram_gnt_i = 1'b0; bus.ram_rvalid_i = 1'b0;
    for (int b = 0; b < 8; b++) begin
      d = {$urandom, $urandom};
      exp_q.push_back('{idx, ew, 3'(b), d});
      bus.ram_rvalid_i = 1'b1; bus.ram_rdata_i = d;
      step();
      bus.ram_rvalid_i = 1'b0;
      if (b < 7) repeat (gap) begin bus.ram_rdata_i = {$urandom, $urandom}; step(); end
    end
    t = 0;
    while (!bus.fill_done_o && t < 8) begin step(); t++; end
    check({name, "_done_seen"}, {63'd0, bus.fill_done_o}, 64'd1);
    if (hen) begin bus.hit_valid_i = 1'b1; bus.hit_index_i = hidx; bus.hit_way_i = hway; end
    step();
    bus.hit_valid_i = 1'b0;
    m_touch(int'(idx), int'(ew));
    if (hen && hidx != idx) m_touch(int'(hidx), int'(hway));
    check({name, "_nwrites"}, 64'(wr_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
      check($sformatf("%s_wr%0d_meta", name, i), {51'd0, wr_q[i].idx, wr_q[i].way, wr_q[i].beat},
            {51'd0, exp_q[i].idx, exp_q[i].way, exp_q[i].beat});
      check($sformatf("%s_wr%0d_data", name, i), wr_q[i].data, exp_q[i].data);
    end
    check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({name, "_done_tag"}, {46'd0, done_tag}, {46'd0, addr[31:14]});
    check({name, "_done_idx"}, {56'd0, done_idx}, {56'd0, idx});
    check({name, "_done_way"}, {62'd0, done_way}, {62'd0, ew});
    check({name, "_latency"}, 64'(done_cyc - acc), 64'(10 + gd + 7 * gap));
  endtask

  typedef struct {
    logic [31:0] addr;
    int          gd;
    int          gap;
    bit          pre;
    logic [7:0]  pidx;
    logic [1:0]  pway;
    bit          hen;
    logic [7:0]  hidx;
    logic [1:0]  hway;
    logic [1:0]  exp_way;
    logic [7:0]  exp_idx;
    logic [17:0] exp_tag;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  ri;
    tbl[0] = '{32'h0001_2340, 0, 0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 2'd0, 8'h8D, 18'h00004};
    tbl[1] = '{32'h0000_0400, 0, 0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 2'd0, 8'h10, 18'h00000};
    tbl[2] = '{32'h0000_4400, 0, 0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 2'd2, 8'h10, 18'h00001};
    tbl[3] = '{32'h0000_8400, 0, 0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 2'd1, 8'h10, 18'h00002};
    tbl[4] = '{32'h0000_C400, 0, 0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 2'd3, 8'h10, 18'h00003};
    tbl[5] = '{32'h0001_0400, 0, 0, 1'b1, 8'h10, 2'd1, 1'b1, 8'h10, 2'd0, 2'd2, 8'h10, 18'h00004};
    tbl[6] = '{32'h0001_4400, 0, 0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 2'd0, 8'h10, 18'h00005};
    tbl[7] = '{32'h0001_8400, 0, 0, 1'b0, 8'h00, 2'd0, 1'b1, 8'h11, 2'd0, 2'd3, 8'h10, 18'h00006};
    tbl[8] = '{32'h0000_0440, 0, 0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 2'd2, 8'h11, 18'h00000};
    tbl[9] = '{32'hDEAD_BEEF, 5, 1, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 2'd0, 2'd0, 8'hFB, 18'h37AB6};

    bus.miss_valid_i = 1'b0; bus.miss_addr_i = '0;
    bus.hit_valid_i = 1'b0; bus.hit_index_i = '0; bus.hit_way_i = '0;
    bus.ram_gnt_i = 1'b0; bus.ram_rvalid_i = 1'b0; bus.ram_rdata_i = '0;
    m_reset();

    repeat (3) step();
    check("rst_ram_req", {63'd0, bus.ram_req_o}, 64'd0);
    check("rst_fill_we", {63'd0, bus.fill_we_o}, 64'd0);
    check("rst_fill_done", {63'd0, bus.fill_done_o}, 64'd0);
    rst_n = 1'b1;
    step();
    check("rst_ready", {63'd0, bus.miss_ready_o}, 64'd1);
    check("rst_outs", {bus.ram_addr_o, 14'd0, bus.fill_index_o, bus.fill_way_o, bus.fill_beat_o, 5'd0},
          64'd0);
    check("rst_data_tag", bus.fill_data_o | {46'd0, bus.fill_tag_o}, 64'd0);

    for (int v = 0; v < 10; v++) begin
      if (tbl[v].pre) do_hit(tbl[v].pidx, tbl[v].pway);
      run_miss($sformatf("vec%0d", v), tbl[v].addr, tbl[v].gd, tbl[v].gap,
               tbl[v].hen, tbl[v].hidx, tbl[v].hway);
      check($sformatf("vec%0d_tbl_way", v), {62'd0, done_way}, {62'd0, tbl[v].exp_way});
      check($sformatf("vec%0d_tbl_idx", v), {56'd0, done_idx}, {56'd0, tbl[v].exp_idx});
      check($sformatf("vec%0d_tbl_tag", v), {46'd0, done_tag}, {46'd0, tbl[v].exp_tag});
    end

    for (int r = 0; r < 24; r++) begin
      ri = 8'h20 + 8'($urandom_range(0, 3));
      a  = ($urandom & 32'hFFFF_C03F) | {18'd0, ri, 6'd0};
      if ($urandom_range(0, 1) == 1) do_hit(8'h20 + 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      run_miss($sformatf("rnd%0d", r), a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), 8'h20 + 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    wr_q.delete();
    done_cnt = 0;
    bus.miss_valid_i = 1'b1; bus.miss_addr_i = 32'h0000_1000;
    step();
    bus.miss_valid_i = 1'b0;
    bus.ram_gnt_i = 1'b1;
    step();
    bus.ram_gnt_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.ram_rvalid_i = 1'b1; bus.ram_rdata_i = {$urandom, $urandom};
      step();
    end
    bus.ram_rvalid_i = 1'b0;
    check("mid_we_before_rst", {63'd0, bus.fill_we_o}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", {63'd0, bus.fill_we_o}, 64'd0);
    check("mid_rst_outs", {bus.ram_addr_o, 14'd0, bus.fill_index_o, bus.fill_way_o, bus.fill_beat_o,
          3'd0, bus.ram_req_o, bus.fill_done_o}, 64'd0);
    check("mid_rst_data_tag", bus.fill_data_o | {46'd0, bus.fill_tag_o}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    m_reset();
    wr_q.delete();
    for (int b = 4; b < 8; b++) begin
      bus.ram_rvalid_i = 1'b1; bus.ram_rdata_i = {$urandom, $urandom};
      step();
    end
    bus.ram_rvalid_i = 1'b0;
    step();
    check("mid_ready_after", {63'd0, bus.miss_ready_o}, 64'd1);
    check("mid_stray_writes", 64'(wr_q.size()), 64'd0);
    check("mid_stray_done", 64'(done_cnt), 64'd0);
    run_miss("post_rst", 32'h0000_1000, 0, 0, 1'b0, 8'h00, 2'd0);
    check("post_rst_way0", {62'd0, done_way}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
